// File: rtl/atm_balance_update.sv
// Account-table transaction engine: authenticates card/password with a linear search and applies a
// deposit or withdrawal to the matched entry, with a per-entry lockout after three wrong passwords.
module atm_balance_update #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 0) ? $clog2(N + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [9:0]       cfg_card,
  input  logic [10:0]      cfg_pwd,
  input  logic [10:0]      cfg_bal,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [9:0]       req_card,
  input  logic [10:0]      req_pwd,
  input  logic             req_op,
  input  logic [10:0]      req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [10:0]      rsp_balance
);

  typedef enum logic [1:0] {IDLE, SEARCH, EXEC, RESP} state_t;
  typedef enum logic [2:0] {
    ST_OK = 3'd0, ST_NO_CARD = 3'd1, ST_BAD_PWD = 3'd2,
    ST_INSUFF = 3'd3, ST_OVERFLOW = 3'd4, ST_LOCKED = 3'd5
  } status_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N);

  state_t           state;
  logic [IDX_W-1:0] k;
  logic             found;
  logic [9:0]       lat_card;
  logic [10:0]      lat_pwd;
  logic             lat_op;
  logic [10:0]      lat_amt;

  logic [9:0]       card_tab [0:N];
  logic [10:0]      pwd_tab  [0:N];
  logic [10:0]      bal_tab  [0:N];
  logic [1:0]       fail_cnt [0:N];

  status_t          exec_status;
  logic [10:0]      exec_bal;
  logic             exec_we;
  logic [1:0]       exec_fail;
  logic [10:0]      cur_bal;
  logic [11:0]      dep_sum;
  logic             cfg_hit;

  assign req_ready = (state == IDLE) && !cfg_we;
  assign cfg_hit   = (state == IDLE) && cfg_we && (32'(cfg_idx) <= 32'(N));

  // Outcome of the EXEC step for entry k, in priority order: lock, password, then arithmetic.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    cur_bal     = bal_tab[k];
    dep_sum     = {1'b0, cur_bal} + {1'b0, lat_amt};
    exec_status = ST_OK;
    exec_bal    = cur_bal;
    exec_we     = 1'b0;
    exec_fail   = fail_cnt[k];
    if (!found) begin
      exec_status = ST_NO_CARD;
      exec_bal    = '0;
    end else if (fail_cnt[k] == 2'd3) begin
      exec_status = ST_LOCKED;
    end else if (pwd_tab[k] != lat_pwd) begin
      exec_status = ST_BAD_PWD;
      exec_fail   = fail_cnt[k] + 2'd1;
    end else begin
      exec_fail = '0;
      if (!lat_op) begin
        if (dep_sum[11]) begin
          exec_status = ST_OVERFLOW;
        end else begin
          exec_bal = dep_sum[10:0];
          exec_we  = 1'b1;
        end
      end else if (lat_amt > cur_bal) begin
        exec_status = ST_INSUFF;
      end else begin
        exec_bal = cur_bal - lat_amt;
        exec_we  = 1'b1;
      end
    end
  end

  // NOTE: the account tables are storage, not control state, so they are deliberately not reset;
  // only writes are suppressed while rst is high so an aborted transaction never lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (cfg_hit) begin
        card_tab[cfg_idx] <= cfg_card;
        pwd_tab[cfg_idx]  <= cfg_pwd;
        bal_tab[cfg_idx]  <= cfg_bal;
      end else if (state == EXEC && exec_we) begin
        bal_tab[k] <= exec_bal;
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_status  <= '0;
      rsp_balance <= '0;
      k           <= '0;
      found       <= 1'b0;
      lat_card    <= '0;
      lat_pwd     <= '0;
      lat_op      <= 1'b0;
      lat_amt     <= '0;
      for (int i = 0; i <= N; i++) fail_cnt[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_hit) begin
            fail_cnt[cfg_idx] <= '0;
          end else if (req_valid && req_ready) begin
            lat_card <= req_card;
            lat_pwd  <= req_pwd;
            lat_op   <= req_op;
            lat_amt  <= req_amt;
            k        <= '0;
            found    <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          // A miss on the last entry still passes through EXEC, which reports NO_CARD.
          if (card_tab[k] == lat_card) begin
            found <= 1'b1;
            state <= EXEC;
          end else if (k == LAST) begin
            state <= EXEC;
          end else begin
            k <= k + 1'b1;
          end
        end
        EXEC: begin
          if (found) fail_cnt[k] <= exec_fail;
          rsp_valid   <= 1'b1;
          rsp_status  <= exec_status;
          rsp_balance <= exec_bal;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_balance_update.sv
// Randomized scoreboard bench for atm_balance_update: an account-level reference model predicts
// each response and its latency; a monitor pops expectations on every response handshake.
module tb_atm_balance_update;

  localparam int N = 3;

  typedef struct {
    int status;
    int bal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [9:0]  cfg_card;
  logic [10:0] cfg_pwd;
  logic [10:0] cfg_bal;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_card;
  logic [10:0] req_pwd;
  logic        req_op;
  logic [10:0] req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [10:0] rsp_balance;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  int m_card [0:N];
  int m_pwd  [0:N];
  int m_bal  [0:N];
  int m_fail [0:N];

  atm_balance_update #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_card(cfg_card), .cfg_pwd(cfg_pwd), .cfg_bal(cfg_bal),
    .req_valid(req_valid), .req_ready(req_ready), .req_card(req_card), .req_pwd(req_pwd),
    .req_op(req_op), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_balance(rsp_balance)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Account-level reference: first matching entry, lockout, password, then the money rules.
  task automatic model_txn(input int card, input int pwd, input int op, input int amt,
                           output exp_t e, output int lat);
    int hit = -1;
    for (int i = 0; i <= N; i++) if (hit < 0 && m_card[i] == card) hit = i;
    if (hit < 0) begin
      e.status = 1; e.bal = 0; lat = N + 3;
      return;
    end
    lat = hit + 3;
    if (m_fail[hit] >= 3) e.status = 5;
    else if (m_pwd[hit] != pwd) begin
      e.status = 2;
      m_fail[hit] = m_fail[hit] + 1;
    end else begin
      m_fail[hit] = 0;
      if (op == 0) begin
        if (m_bal[hit] + amt > 2047) e.status = 4;
        else begin m_bal[hit] = m_bal[hit] + amt; e.status = 0; end
      end else begin
        if (amt > m_bal[hit]) e.status = 3;
        else begin m_bal[hit] = m_bal[hit] - amt; e.status = 0; end
      end
    end
    e.bal = m_bal[hit];
  endtask

  task automatic cfg_write(input int idx, input int card, input int pwd, input int bal,
                           input bit with_req);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_card = 10'(card); cfg_pwd = 11'(pwd); cfg_bal = 11'(bal);
    req_valid = with_req; req_card = 10'(card); req_pwd = 11'(pwd); req_op = 1'b1; req_amt = 11'd1;
    @(negedge clk);
    check("req_ready_during_cfg", int'(req_ready), 0);
    @(posedge clk); #1;
    cfg_we = 1'b0; req_valid = 1'b0;
    m_card[idx] = card; m_pwd[idx] = pwd; m_bal[idx] = bal; m_fail[idx] = 0;
  endtask

  task automatic txn(input int card, input int pwd, input int op, input int amt, input int hold);
    exp_t e;
    int lat, c;
    int s0, b0;
    model_txn(card, pwd, op, amt, e, lat);
    @(posedge clk); #1;
    req_card = 10'(card); req_pwd = 11'(pwd); req_op = op[0]; req_amt = 11'(amt); req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_idle", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_card = 10'($urandom); req_pwd = 11'($urandom); req_op = 1'($urandom); req_amt = 11'($urandom);
    exp_q.push_back(e);
    c = 1;
    @(negedge clk);
    while (!rsp_valid && c < 64) begin
      @(negedge clk);
      c++;
    end
    check("latency", c, lat);
    s0 = int'(rsp_status); b0 = int'(rsp_balance);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", int'(rsp_valid), 1);
      check("hold_status", int'(rsp_status), s0);
      check("hold_balance", int'(rsp_balance), b0);
      check("hold_req_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", int'(rsp_valid), 0);
  endtask

  // Reset strikes in cycle 'when' after the accept; the transaction must leave no trace.
  task automatic abort_txn(input int card, input int pwd, input int op, input int amt, input int when);
    @(posedge clk); #1;
    req_card = 10'(card); req_pwd = 11'(pwd); req_op = op[0]; req_amt = 11'(amt); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (when - 1) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", int'(rsp_valid), 0);
    check("abort_rsp_status", int'(rsp_status), 0);
    check("abort_rsp_balance", int'(rsp_balance), 0);
    check("abort_req_ready", int'(req_ready), 1);
    for (int i = 0; i <= N; i++) m_fail[i] = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_status", int'(rsp_status), e.status);
          check("rsp_balance", int'(rsp_balance), e.bal);
        end
      end
    end
  end

  initial begin : stimulus
    int cards [6] = '{5, 11, 22, 33, 44, 1000};
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_card = '0; cfg_pwd = '0; cfg_bal = '0;
    req_valid = 1'b0; req_card = '0; req_pwd = '0; req_op = 1'b0; req_amt = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_status", int'(rsp_status), 0);
    check("reset_rsp_balance", int'(rsp_balance), 0);
    check("reset_req_ready", int'(req_ready), 1);
    @(posedge clk); #1 rst = 1'b0;

    cfg_write(0, 11, 1, 10, 1'b1);
    cfg_write(1, 22, 2, 2047, 1'b0);
    cfg_write(2, 5, 100, 500, 1'b1);
    cfg_write(3, 33, 3, 0, 1'b0);

    txn(5, 100, 1, 200, 0);             // OK 300, latency 5
    cfg_write(2, 5, 100, 500, 1'b0);
    txn(5, 100, 0, 1600, 0);            // OVERFLOW
    txn(5, 100, 1, 501, 0);             // INSUFFICIENT
    txn(999, 7, 1, 1, 0);               // NO_CARD, latency N+3
    txn(5, 100, 0, 1547, 0);            // exactly 2047
    txn(22, 2, 0, 0, 0);                // amount 0 at full balance
    txn(5, 100, 1, 2047, 0);            // exactly to 0
    txn(11, 1, 1, 0, 5);                // stalled response
    repeat (3) txn(22, 9, 1, 5, 0);     // BAD_PWD x3
    txn(22, 2, 1, 5, 0);                // LOCKED
    cfg_write(1, 22, 2, 700, 1'b0);
    txn(22, 2, 1, 5, 0);                // unlocked again
    cfg_write(3, 5, 42, 77, 1'b0);      // duplicate card: index 2 still wins
    txn(5, 42, 0, 1, 0);
    txn(5, 100, 0, 9, 0);

    for (int w = 1; w <= 3; w++) begin
      abort_txn(22, 2, 1, 100, w);
      txn(22, 2, 1, 0, 0);              // original balance survives
    end

    for (int n = 0; n < 60; n++) begin
      int j, card, pwd;
      if ($urandom_range(9) == 0) begin
        cfg_write(int'($urandom_range(N)), cards[$urandom_range(4)], int'($urandom_range(3)),
                  int'($urandom_range(2047)), 1'($urandom));
      end
      j = int'($urandom_range(N));
      card = ($urandom_range(7) == 0) ? cards[5] + int'($urandom_range(20)) : m_card[j];
      pwd  = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : m_pwd[j];
      txn(card, pwd, int'($urandom_range(1)),
          ($urandom_range(1) == 0) ? int'($urandom_range(300)) : int'($urandom_range(2047)),
          int'($urandom_range(3)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
